// File: rtl/arith_unit_seq.sv
// arith_unit_seq: registered ADD/SUB/MUL/MAC unit, 1-bit/cycle shift-add multiplier.
// Ports: clk, nRST; in_valid/in_ready/op/a/b/acc_clr in; out_valid/out_ready/result/out_op, busy out.
module arith_unit_seq #(
   parameter int WIDTH = 32,
   parameter int ACC_W = 2*WIDTH+8
) (
   input  logic             clk,
   input  logic             nRST,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] result,
   output logic [1:0]       out_op,
   output logic             busy
);

   localparam int PW = 2*WIDTH;
   localparam int CW = $clog2(WIDTH) + 1;

   localparam logic [1:0] OP_MAC = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDSUB,
      S_MUL,
      S_ACC,
      S_DONE
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [1:0]       op_q;
   logic [PW-1:0]    mcand_q;
   logic [PW-1:0]    prod_q;
   logic [CW-1:0]    cnt_q;
   logic [ACC_W-1:0] acc_q;
   logic [ACC_W-1:0] result_q;
   logic [1:0]       out_op_q;
   logic             out_valid_q;

   logic             accept;
   logic             last_bit;
   logic [WIDTH:0]   addsub_d;
   logic [PW-1:0]    prod_d;
   logic [ACC_W-1:0] acc_base_d;
   logic [ACC_W-1:0] acc_d;

   assign in_ready  = (state_q == S_IDLE) |
                      ((state_q == S_DONE) & out_ready);
   assign accept    = in_valid & in_ready;
   assign busy      = (state_q != S_IDLE);
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign out_op    = out_op_q;
   assign last_bit  = (cnt_q == CW'(WIDTH-1));

   always_comb begin
      // op_q[0] selects SUB; the extra top bit carries the carry/borrow
      addsub_d   = op_q[0] ? ({1'b0, a_q} - {1'b0, b_q})
                           : ({1'b0, a_q} + {1'b0, b_q});
      // b_q is shifted right each cycle, so bit 0 is the current multiplier bit
      prod_d     = b_q[0] ? (prod_q + mcand_q) : prod_q;
      // a clear on the accumulate edge wins over the old value, not the product
      acc_base_d = acc_clr ? '0 : acc_q;
      acc_d      = acc_base_d + ACC_W'(prod_q);
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         mcand_q     <= '0;
         prod_q      <= '0;
         cnt_q       <= '0;
         acc_q       <= '0;
         result_q    <= '0;
         out_op_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         if (acc_clr) begin
            acc_q <= '0;
         end
         unique case (state_q)
            S_IDLE: begin
            end
            S_ADDSUB: begin
               result_q    <= ACC_W'(addsub_d);
               out_op_q    <= op_q;
               out_valid_q <= 1'b1;
               state_q     <= S_DONE;
            end
            S_MUL: begin
               prod_q  <= prod_d;
               mcand_q <= mcand_q << 1;
               b_q     <= b_q >> 1;
               cnt_q   <= cnt_q + CW'(1);
               if (last_bit) begin
                  if (op_q == OP_MAC) begin
                     state_q <= S_ACC;
                  end else begin
                     result_q    <= ACC_W'(prod_d);
                     out_op_q    <= op_q;
                     out_valid_q <= 1'b1;
                     state_q     <= S_DONE;
                  end
               end
            end
            S_ACC: begin
               acc_q       <= acc_d;
               result_q    <= acc_d;
               out_op_q    <= op_q;
               out_valid_q <= 1'b1;
               state_q     <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
         // accept only happens in IDLE or DONE, so it overrides the retire above
         if (accept) begin
            a_q     <= a;
            b_q     <= b;
            op_q    <= op;
            mcand_q <= PW'(a);
            prod_q  <= '0;
            cnt_q   <= '0;
            state_q <= op[1] ? S_MUL : S_ADDSUB;
         end
      end
   end

endmodule

// File: tb/tb_arith_unit_seq.sv
// tb_arith_unit_seq: scoreboard bench for arith_unit_seq.
// Two instances: WIDTH=8 (random + directed) and WIDTH=32 (wide multiply).
module tb_arith_unit_seq;

   localparam int W   = 8;
   localparam int AW  = 2*W+8;
   localparam int W2  = 32;
   localparam int AW2 = 2*W2+8;

   logic          clk;
   logic          nRST;

   logic          in_valid;
   logic          in_ready;
   logic [1:0]    op;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          acc_clr;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [AW-1:0] result;
   logic [1:0]    out_op;
   logic          busy;

   logic           in_valid32;
   logic           in_ready32;
   logic [1:0]     op32;
   logic [W2-1:0]  a32;
   logic [W2-1:0]  b32;
   logic           acc_clr32;
   logic           out_valid32;
   logic           out_ready32;
   logic [AW2-1:0] result32;
   logic [1:0]     out_op32;
   logic           busy32;

   arith_unit_seq #(.WIDTH(W), .ACC_W(AW)) u_dut (
      .clk(clk), .nRST(nRST),
      .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .acc_clr(acc_clr),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .out_op(out_op), .busy(busy)
   );

   arith_unit_seq #(.WIDTH(W2), .ACC_W(AW2)) u_dut32 (
      .clk(clk), .nRST(nRST),
      .in_valid(in_valid32), .in_ready(in_ready32),
      .op(op32), .a(a32), .b(b32), .acc_clr(acc_clr32),
      .out_valid(out_valid32), .out_ready(out_ready32),
      .result(result32), .out_op(out_op32), .busy(busy32)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int n_done = 0;
   logic [AW-1:0] last_res = '0;
   int rdy_mode = 2;
   logic clr_rand = 1'b0;

   typedef struct {
      logic [AW-1:0] res;
      logic [1:0]    op;
      int            vis;
   } exp_t;

   exp_t sb[$];

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask

   task automatic fail(input string nm);
      tests++;
      fails++;
      $display("FAIL %s: got timeout required completion", nm);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #2;
      out_ready = (rdy_mode == 0) ? ($urandom_range(0, 2) != 0)
                                  : (rdy_mode == 2);
   end

   // reference model: spec arithmetic, spec latencies, edge-indexed acc
   logic          mac_pend = 1'b0;
   int            mac_edge = 0;
   logic [AW-1:0] mac_prod = '0;
   logic [AW-1:0] model_acc = '0;
   int unsigned   mx, my;
   int            me;

   always @(negedge clk) begin
      if (!nRST) begin
         sb.delete();
         mac_pend  = 1'b0;
         model_acc = '0;
      end else begin
         if (mac_pend && mac_edge == cyc + 1) begin
            model_acc = (acc_clr ? '0 : model_acc) + mac_prod;
            sb.push_back('{res: model_acc, op: 2'b11, vis: mac_edge});
            mac_pend = 1'b0;
         end else if (acc_clr) begin
            model_acc = '0;
         end
         if (in_valid && in_ready) begin
            mx = a;
            my = b;
            me = cyc + 1;
            if (op == 2'b00)
               sb.push_back('{res: AW'(mx + my), op: op, vis: me + 1});
            else if (op == 2'b01)
               sb.push_back('{res: AW'((mx - my) & ((1 << (W+1)) - 1)),
                              op: op, vis: me + 1});
            else if (op == 2'b10)
               sb.push_back('{res: AW'(mx * my), op: op, vis: me + W});
            else begin
               mac_pend = 1'b1;
               mac_edge = me + W + 1;
               mac_prod = AW'(mx * my);
            end
         end
      end
   end

   // monitor: pops on each new result, checks hold while stalled
   logic          pv = 1'b0;
   logic [AW-1:0] hold_res = '0;
   logic [1:0]    hold_op = '0;
   exp_t          ex;

   always @(negedge clk) begin
      if (!nRST) begin
         pv = 1'b0;
      end else begin
         if (out_valid && !pv) begin
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_result: got %0h required none", result);
            end else begin
               ex = sb.pop_front();
               chk("result", result, ex.res);
               chk("out_op", out_op, ex.op);
               chk("latency", cyc, ex.vis);
               last_res = result;
               n_done++;
            end
            hold_res = result;
            hold_op  = out_op;
         end else if (out_valid) begin
            chk("hold_result", result, hold_res);
            chk("hold_op", out_op, hold_op);
         end
         if (out_valid) chk("in_ready_done", in_ready, out_ready);
         pv = out_valid;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      acc_clr = clr_rand && ($urandom_range(0, 9) == 0);
   endtask

   task automatic issue(input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y);
      int n = 0;
      in_valid = 1'b1;
      op = o;
      a  = x;
      b  = y;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 300) begin
            fail("accept_timeout");
            break;
         end
         tick();
      end
      tick();
      in_valid = 1'b0;
      op = 2'($urandom);
      a  = W'($urandom);
      b  = W'($urandom);
   endtask

   task automatic wait_res();
      int n0 = n_done;
      for (int i = 0; i < 100; i++) begin
         if (n_done > n0) return;
         tick();
      end
      fail("wait_res_timeout");
   endtask

   task automatic run32(input logic [1:0] o, input logic [W2-1:0] x,
                        input logic [W2-1:0] y, input logic [AW2-1:0] exp,
                        input int lat);
      int k = 0;
      in_valid32 = 1'b1;
      op32 = o;
      a32  = x;
      b32  = y;
      @(negedge clk);
      chk("w32_in_ready", in_ready32, 1'b1);
      tick();
      in_valid32 = 1'b0;
      op32 = 2'($urandom);
      a32  = $urandom;
      b32  = $urandom;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (out_valid32) begin
            k = i;
            break;
         end
      end
      if (k == 0) begin
         fail("w32_timeout");
      end else begin
         chk("w32_latency", k, lat + 1);
         chk("w32_result", result32, exp);
         chk("w32_out_op", out_op32, o);
      end
      tick();
   endtask

   logic [W2-1:0] rx, ry;

   initial begin
      nRST = 1'b1;
      in_valid = 1'b0;
      op = '0;
      a = '0;
      b = '0;
      acc_clr = 1'b0;
      in_valid32 = 1'b0;
      op32 = '0;
      a32 = '0;
      b32 = '0;
      acc_clr32 = 1'b0;
      out_ready32 = 1'b1;

      #2 nRST = 1'b0;
      #1;
      chk("rst_result", result, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_op", out_op, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_result32", result32, 0);
      #18 nRST = 1'b1;
      tick();

      // wide multiply
      run32(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF,
            AW2'(64'hFFFFFFFE00000001), W2);
      rx = $urandom;
      ry = $urandom;
      run32(2'b10, rx, ry, AW2'({32'h0, rx} * {32'h0, ry}), W2);
      run32(2'b00, 32'hFFFFFFFF, 32'h1, AW2'(64'h100000000), 1);

      // add / sub boundaries
      issue(2'b00, 8'd200, 8'd100);
      wait_res();
      chk("t1_add", last_res, 300);
      issue(2'b01, 8'd5, 8'd7);
      wait_res();
      chk("t2_sub_borrow", last_res, 24'h1FE);
      issue(2'b01, 8'd7, 8'd5);
      wait_res();
      chk("t2_sub", last_res, 2);
      issue(2'b10, 8'hFF, 8'hFF);
      wait_res();
      chk("mul_max", last_res, 24'hFE01);

      // stalled result, then retire and accept on one edge
      issue(2'b00, 8'd10, 8'd20);
      rdy_mode = 1;
      repeat (6) tick();
      chk("t5_held_valid", out_valid, 1);
      chk("t5_held_ready", in_ready, 0);
      rdy_mode = 2;
      issue(2'b01, 8'd9, 8'd3);
      chk("t5_retired", out_valid, 0);
      chk("t5_busy", busy, 1);
      wait_res();
      chk("t5_sub", last_res, 6);

      // random traffic
      clr_rand = 1'b1;
      rdy_mode = 0;
      for (int i = 0; i < 150; i++) begin
         issue(2'($urandom), W'($urandom), W'($urandom));
         repeat ($urandom_range(0, 2)) tick();
      end
      clr_rand = 1'b0;
      rdy_mode = 2;
      for (int i = 0; i < 200; i++) begin
         if (sb.size() == 0 && !mac_pend && !out_valid) break;
         tick();
      end
      chk("drain_empty", sb.size(), 0);

      // accumulate with clear
      acc_clr = 1'b1;
      tick();
      issue(2'b11, 8'd3, 8'd4);
      wait_res();
      chk("t4_mac1", last_res, 12);
      issue(2'b11, 8'd5, 8'd6);
      wait_res();
      chk("t4_mac2", last_res, 42);
      issue(2'b11, 8'd2, 8'd2);
      repeat (W) tick();
      acc_clr = 1'b1;
      tick();
      wait_res();
      chk("t4_mac3_clr", last_res, 4);

      // reset mid-multiply
      issue(2'b10, 8'd9, 8'd13);
      repeat (4) tick();
      chk("t6_busy_mid", busy, 1);
      nRST = 1'b0;
      #1;
      chk("t6_result", result, 0);
      chk("t6_out_valid", out_valid, 0);
      chk("t6_out_op", out_op, 0);
      chk("t6_busy", busy, 0);
      chk("t6_in_ready", in_ready, 1);
      tick();
      tick();
      nRST = 1'b1;
      tick();
      issue(2'b00, 8'd1, 8'd1);
      wait_res();
      chk("t6_add", last_res, 2);
      issue(2'b11, 8'd1, 8'd1);
      wait_res();
      chk("t6_acc_zero", last_res, 1);
      repeat (3) tick();
      chk("final_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
